// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle for the bit-serial add/subtract controller.
// The master issues start requests and the slave (the controller) returns the results.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             iStart;
    logic             iSub;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oBusy;
    logic             oDone;
    logic [WIDTH-1:0] oSum;
    logic             oCout;
    logic             oOvf;

    modport master (
        output iStart, iSub, iA, iB,
        input  oBusy, oDone, oSum, oCout, oOvf
    );

    modport slave (
        input  iStart, iSub, iA, iB,
        output oBusy, oDone, oSum, oCout, oOvf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first, WIDTH cycles per op.
// Subtraction is A + ~B + 1, with the +1 entering through the carry flop.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               iClk,
    input  logic               iRst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic cell_sum;
    logic cell_carry;
    logic start_ok;

    assign cell_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign cell_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign start_ok   = bus.iStart && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    a_d     = bus.iA;
                    b_d     = bus.iSub ? ~bus.iB : bus.iB;
                    carry_d = bus.iSub;
                    cnt_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d   = {cell_sum, sum_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = cell_carry;
                cnt_d   = cnt_q + CW'(1);
                // On the MSB, carry_q is the carry into the sign bit.
                if (cnt_q == LAST) begin
                    cout_d  = cell_carry;
                    ovf_d   = carry_q ^ cell_carry;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.oBusy = (state_q == S_RUN);
    assign bus.oDone = (state_q == S_DONE);
    assign bus.oSum  = sum_q;
    assign bus.oCout = cout_q;
    assign bus.oOvf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus queues expected results,
// a negedge monitor pops and checks them whenever oDone is seen.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   ecount = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_run = 0;
    exp_t q[$];

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endfunction

    // Monitor: pops one expected result per oDone, flags missing and extra pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (bus.oBusy) busy_run++;
            if (bus.oDone) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got oDone=1 at edge %0d, want no pulse", ecount);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("op %s: sum=0x%02h cout=%0d ovf=%0d edge=%0d busy_cycles=%0d",
                             e.name, bus.oSum, bus.oCout, bus.oOvf, ecount, busy_run);
                    chk({e.name, "_sum"},   int'(bus.oSum),  int'(e.sum));
                    chk({e.name, "_cout"},  int'(bus.oCout), int'(e.cout));
                    chk({e.name, "_ovf"},   int'(bus.oOvf),  int'(e.ovf));
                    chk({e.name, "_edge"},  ecount,          e.cyc);
                    chk({e.name, "_busyn"}, busy_run,        W);
                    chk({e.name, "_busy0"}, int'(bus.oBusy), 0);
                end
                busy_run = 0;
            end else if (q.size() > 0 && ecount > q[0].cyc) begin
                exp_t e;
                e = q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL %s_done_missing: got no oDone by edge %0d, want pulse at edge %0d",
                         e.name, ecount, e.cyc);
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                            input bit expect_result, input string name,
                            input logic [W-1:0] esum, input logic ecout, input logic eovf);
        exp_t e;
        bus.iA     = a;
        bus.iB     = b;
        bus.iSub   = sub;
        bus.iStart = 1'b1;
        if (expect_result) begin
            e.sum  = esum;
            e.cout = ecout;
            e.ovf  = eovf;
            e.cyc  = ecount + W + 1;
            e.name = name;
            q.push_back(e);
        end
        @(negedge clk);
        bus.iStart = 1'b0;
        bus.iA     = W'($urandom);
        bus.iB     = W'($urandom);
        bus.iSub   = 1'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.iStart = 1'b0;
        bus.iSub   = 1'b0;
        bus.iA     = '0;
        bus.iB     = '0;
        wait_cycles(3);
        #1;
        chk("rst_busy", int'(bus.oBusy), 0);
        chk("rst_done", int'(bus.oDone), 0);
        chk("rst_sum",  int'(bus.oSum),  0);
        chk("rst_cout", int'(bus.oCout), 0);
        chk("rst_ovf",  int'(bus.oOvf),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(8'h3C, 8'h55, 1'b0, 1'b1, "add_3c_55", 8'h91, 1'b0, 1'b1);
        wait_cycles(10);
        start_op(8'hFF, 8'h01, 1'b0, 1'b1, "add_ff_01", 8'h00, 1'b1, 1'b0);
        wait_cycles(10);
        start_op(8'h7F, 8'h01, 1'b0, 1'b1, "add_7f_01", 8'h80, 1'b0, 1'b1);
        wait_cycles(10);
        start_op(8'h10, 8'h20, 1'b1, 1'b1, "sub_10_20", 8'hF0, 1'b0, 1'b0);
        wait_cycles(10);
        start_op(8'h80, 8'h01, 1'b1, 1'b1, "sub_80_01", 8'h7F, 1'b1, 1'b1);
        wait_cycles(10);
        start_op(8'h55, 8'h55, 1'b1, 1'b1, "sub_55_55", 8'h00, 1'b1, 1'b0);
        wait_cycles(10);

        // A start pulse in the middle of RUN must be dropped.
        start_op(8'h01, 8'h02, 1'b0, 1'b1, "add_01_02", 8'h03, 1'b0, 1'b0);
        wait_cycles(2);
        start_op(8'hAA, 8'h55, 1'b0, 1'b0, "ignored", 8'h00, 1'b0, 1'b0);
        wait_cycles(14);

        // Back-to-back: second start lands on the DONE cycle of the first.
        start_op(8'h05, 8'h06, 1'b0, 1'b1, "add_05_06", 8'h0B, 1'b0, 1'b0);
        wait_cycles(W);
        start_op(8'h0F, 8'h01, 1'b0, 1'b1, "b2b_0f_01", 8'h10, 1'b0, 1'b0);
        wait_cycles(12);

        // Reset in the middle of RUN clears everything immediately.
        start_op(8'h11, 8'h22, 1'b0, 1'b0, "aborted", 8'h00, 1'b0, 1'b0);
        wait_cycles(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.oBusy), 0);
        chk("midrst_done", int'(bus.oDone), 0);
        chk("midrst_sum",  int'(bus.oSum),  0);
        chk("midrst_cout", int'(bus.oCout), 0);
        chk("midrst_ovf",  int'(bus.oOvf),  0);
        wait_cycles(2);
        rst_n = 1'b1;
        start_op(8'h01, 8'h01, 1'b0, 1'b1, "post_rst_01_01", 8'h02, 1'b0, 1'b0);
        wait_cycles(14);

        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
